cordic_twiddle_sched: RTL and testbench

Sequences one radix-2 FFT stage through the pipelined 16-bit CORDIC rotator. For every butterfly it accepts the lower-leg operand, computes the stage's twiddle angle in the CORDIC's 32-bit binary-angle format and issues operand plus angle into the rotator. It tracks the rotator's fixed pipeline latency with a valid/index delay line and presents each rotated result with its butterfly index. It signals completion once the stage has fully drained. It sits between the FFT sample-memory reader and the butterfly add/subtract unit.

---
 rtl/cordic_fft_pkg.sv | 26 ++
 rtl/cordic_tag_pipe.sv | 34 +++
 rtl/cordic_twiddle_sched.sv | 133 +++++++++++++
 tb/tb_cordic_twiddle_sched.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_fft_pkg.sv
// Shared types and constants for the CORDIC-based FFT datapath.
//   DATA_W / ANGLE_W / CORDIC_LAT : rotator operand width, binary-angle width
//                                    (2^ANGLE_W = 360 deg) and pipeline latency.
//   sched_state_t                 : butterfly scheduler FSM states.
//   twiddle_angle(b, s, log2n)    : DIT twiddle angle for butterfly b of stage s.
package cordic_fft_pkg;

  localparam int DATA_W     = 16;
  localparam int ANGLE_W    = 32;
  localparam int CORDIC_LAT = 16;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} sched_state_t;

  // e = (b mod 2^s) << (log2n-1-s); angle = -(e << (ANGLE_W-log2n)) mod 2^ANGLE_W.
  // e < N/2, so the magnitude always stays below 180 deg and the result is exact.
  function automatic logic [ANGLE_W-1:0] twiddle_angle(input logic [31:0] b,
                                                       input logic [31:0] s,
                                                       input int          log2n);
    logic [31:0] s_eff, mask, e;
    s_eff = (s >= 32'(log2n)) ? 32'(log2n - 1) : s;
    mask  = (32'd1 << s_eff) - 32'd1;
    e     = (b & mask) << (32'(log2n - 1) - s_eff);
    return ANGLE_W'(32'd0 - (e << 32'(ANGLE_W - log2n)));
  endfunction

endpackage

// File: rtl/cordic_tag_pipe.sv
// {valid, idx} delay line that shadows the CORDIC rotator pipeline so each
// rotated result comes out tagged with the butterfly it belongs to.
//   clock, reset_n      : clock, async active-low clear (drops all tags)
//   in_valid, in_idx    : tag entering alongside the rotator input register
//   out_valid, out_idx  : tag aligned with the rotator output
module cordic_tag_pipe #(
  parameter int DEPTH = 16,
  parameter int IDX_W = 2
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  input  logic [IDX_W-1:0] in_idx,
  output logic             out_valid,
  output logic [IDX_W-1:0] out_idx
);

  logic [DEPTH-1:0]            vld_pipe;
  logic [DEPTH-1:0][IDX_W-1:0] idx_pipe;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vld_pipe <= '0;
      idx_pipe <= '0;
    end else begin
      vld_pipe <= {vld_pipe[DEPTH-2:0], in_valid};
      idx_pipe <= {idx_pipe[DEPTH-2:0], in_idx};
    end
  end

  assign out_valid = vld_pipe[DEPTH-1];
  assign out_idx   = idx_pipe[DEPTH-1];

endmodule

// File: rtl/cordic_twiddle_sched.sv
// Schedules one radix-2 FFT stage through a pipelined CORDIC rotator: accepts
// the lower-leg operand per butterfly, issues it with its twiddle angle, and
// tags results with the butterfly index as they leave the rotator.
//   clock, reset_n            : clock, async active-low reset
//   start, stage              : stage kick-off (ignored while busy), stage index
//   busy, done                : stage in progress, one-cycle completion pulse
//   in_valid/in_ready, in_x/y : operand handshake from the sample reader
//   cordic_angle/xin/yin      : registered rotator inputs
//   cordic_xout/yout          : rotator outputs
//   out_valid/idx/x/y         : tagged rotated result (no backpressure)
module cordic_twiddle_sched #(
  parameter int LOG2N      = 3,
  parameter int DATA_W     = cordic_fft_pkg::DATA_W,
  parameter int ANGLE_W    = cordic_fft_pkg::ANGLE_W,
  parameter int CORDIC_LAT = cordic_fft_pkg::CORDIC_LAT
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic [LOG2N-1:0]         stage,
  output logic                     busy,
  output logic                     done,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_x,
  input  logic signed [DATA_W-1:0] in_y,
  output logic [ANGLE_W-1:0]       cordic_angle,
  output logic signed [DATA_W-1:0] cordic_xin,
  output logic signed [DATA_W-1:0] cordic_yin,
  input  logic signed [DATA_W-1:0] cordic_xout,
  input  logic signed [DATA_W-1:0] cordic_yout,
  output logic                     out_valid,
  output logic [LOG2N-2:0]         out_idx,
  output logic signed [DATA_W-1:0] out_x,
  output logic signed [DATA_W-1:0] out_y
);
  import cordic_fft_pkg::*;

  localparam int IDX_W = LOG2N - 1;
  // Sized one above CORDIC_LAT: the rotator input register holds one extra tag.
  localparam int CNT_W = $clog2(CORDIC_LAT + 2);
  localparam logic [IDX_W-1:0] B_LAST = '1;  // N/2-1

  sched_state_t     state_q, state_d;
  logic [LOG2N-1:0] stage_q;
  logic [IDX_W-1:0] b_q;
  logic [CNT_W-1:0] infl_q, infl_d;
  logic             accept, kick;
  logic             iss_vld_q;
  logic [IDX_W-1:0] iss_idx_q;

  assign kick     = (state_q == IDLE) && start;
  assign accept   = (state_q == RUN) && in_valid;
  assign in_ready = (state_q == RUN);
  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);

  always_comb begin
    infl_d = infl_q;
    case ({accept, out_valid})
      2'b10:   infl_d = infl_q + CNT_W'(1);
      2'b01:   infl_d = infl_q - CNT_W'(1);
      default: infl_d = infl_q;
    endcase
  end

  // DRAIN looks at the next count so done lands right after the last result.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (accept && (b_q == B_LAST)) state_d = DRAIN;
      DRAIN:   if (infl_d == '0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      stage_q <= '0;
      b_q     <= '0;
      infl_q  <= '0;
    end else begin
      state_q <= state_d;
      if (kick) begin
        stage_q <= stage;
        b_q     <= '0;
        infl_q  <= '0;
      end else begin
        if (accept) b_q <= b_q + IDX_W'(1);
        infl_q <= infl_d;
      end
    end
  end

  // Rotator input register; holds between transfers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cordic_angle <= '0;
      cordic_xin   <= '0;
      cordic_yin   <= '0;
      iss_vld_q    <= 1'b0;
      iss_idx_q    <= '0;
    end else begin
      iss_vld_q <= accept;
      if (accept) begin
        cordic_angle <= ANGLE_W'(twiddle_angle(32'(b_q), 32'(stage_q), LOG2N));
        cordic_xin   <= in_x;
        cordic_yin   <= in_y;
        iss_idx_q    <= b_q;
      end
    end
  end

  // Tags ride from the rotator input register, so they emerge with its output.
  cordic_tag_pipe #(
    .DEPTH (CORDIC_LAT),
    .IDX_W (IDX_W)
  ) u_tag_pipe (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (iss_vld_q),
    .in_idx    (iss_idx_q),
    .out_valid (out_valid),
    .out_idx   (out_idx)
  );

  assign out_x = cordic_xout;
  assign out_y = cordic_yout;

endmodule

// File: tb/tb_cordic_twiddle_sched.sv
// Directed bench for cordic_twiddle_sched with a behavioural 16-cycle rotator.
module tb_cordic_twiddle_sched;
  localparam int LOG2N = 3;
  localparam int LAT   = 16;

  logic               clock = 1'b0;
  logic               reset_n = 1'b0;
  logic               start = 1'b0;
  logic [LOG2N-1:0]   stage = '0;
  logic               busy, done, in_ready, out_valid;
  logic               in_valid = 1'b0;
  logic signed [15:0] in_x = '0, in_y = '0;
  logic [31:0]        cordic_angle;
  logic signed [15:0] cordic_xin, cordic_yin, cordic_xout, cordic_yout;
  logic [LOG2N-2:0]   out_idx;
  logic signed [15:0] out_x, out_y;

  always #5 clock = ~clock;

  cordic_twiddle_sched #(.LOG2N(LOG2N)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .stage(stage),
    .busy(busy), .done(done), .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_y(in_y), .cordic_angle(cordic_angle),
    .cordic_xin(cordic_xin), .cordic_yin(cordic_yin),
    .cordic_xout(cordic_xout), .cordic_yout(cordic_yout),
    .out_valid(out_valid), .out_idx(out_idx), .out_x(out_x), .out_y(out_y)
  );

  // Rotator model: ideal rotation of the registered input, LAT cycles later.
  logic signed [15:0] rx [LAT];
  logic signed [15:0] ry [LAT];
  real rot_a;

  function automatic logic signed [15:0] rnd(input real v);
    if (v >= 0.0) return 16'($rtoi(v + 0.5));
    else          return 16'($rtoi(v - 0.5));
  endfunction

  always @(posedge clock) begin
    rot_a = $itor($signed(cordic_angle)) * 3.14159265358979 / 2147483648.0;
    for (int i = LAT - 1; i > 0; i--) begin
      rx[i] <= rx[i-1];
      ry[i] <= ry[i-1];
    end
    rx[0] <= rnd($itor(cordic_xin) * $cos(rot_a) - $itor(cordic_yin) * $sin(rot_a));
    ry[0] <= rnd($itor(cordic_xin) * $sin(rot_a) + $itor(cordic_yin) * $cos(rot_a));
  end
  assign cordic_xout = rx[LAT-1];
  assign cordic_yout = ry[LAT-1];

  // Output monitor
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int oq_idx[$], oq_x[$], oq_y[$], oq_cyc[$];
  int done_cnt = 0, done_cyc = 0;
  always @(negedge clock) begin
    if (out_valid) begin
      oq_idx.push_back(int'(out_idx));
      oq_x.push_back(int'(out_x));
      oq_y.push_back(int'(out_y));
      oq_cyc.push_back(cyc);
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  int errors = 0, checks = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_tol(input string tag, input int obs, input int exp, input int tol);
    checks++;
    assert ((obs - exp) <= tol && (exp - obs) <= tol) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d +/-%0d", tag, obs, exp, tol);
    end
  endtask

  logic [31:0] exp_ang [4];
  int opx [4], opy [4];
  int acc_cyc[$];

  // Runs one stage of 4 butterflies; in_valid is high every `period` cycles.
  task automatic do_stage(input string tag, input logic [LOG2N-1:0] s,
                          input int period, input bit poke_start);
    int k, p, guard, d0;
    logic rdy;
    oq_idx.delete(); oq_x.delete(); oq_y.delete(); oq_cyc.delete();
    acc_cyc.delete();
    d0 = done_cnt;
    @(negedge clock); stage = s; start = 1'b1;
    @(negedge clock); start = 1'b0; stage = 3'd0;
    chk($sformatf("%s busy_rise", tag), 64'(busy), 64'd1);
    k = 0; p = 0; guard = 0;
    while (k < 4 && guard < 200) begin
      in_valid = ((p % period) == 0);
      in_x = 16'(opx[k]);
      in_y = 16'(opy[k]);
      if (poke_start && p == 2) begin start = 1'b1; stage = 3'd0; end
      else start = 1'b0;
      rdy = in_ready;
      @(posedge clock); #1;
      if (rdy && in_valid) begin
        chk($sformatf("%s angle b%0d", tag, k), 64'(cordic_angle), 64'(exp_ang[k]));
        acc_cyc.push_back(cyc);
        k++;
      end
      p++; guard++;
      @(negedge clock);
    end
    in_valid = 1'b0; start = 1'b0;
    chk($sformatf("%s accepts", tag), 64'(k), 64'd4);
    guard = 0;
    while (done_cnt == d0 && guard < 100) begin
      @(negedge clock); guard++;
    end
    repeat (3) @(negedge clock);
    chk($sformatf("%s done_pulses", tag), 64'(done_cnt), 64'(d0 + 1));
    chk($sformatf("%s out_count", tag), 64'(oq_idx.size()), 64'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < oq_idx.size() && i < acc_cyc.size()) begin
        chk($sformatf("%s out_idx%0d", tag, i), 64'(oq_idx[i]), 64'(i));
        chk($sformatf("%s out_cyc%0d", tag, i), 64'(oq_cyc[i]), 64'(acc_cyc[i] + LAT));
      end
    end
    if (oq_cyc.size() == 4)
      chk($sformatf("%s done_cyc", tag), 64'(done_cyc), 64'(oq_cyc[3] + 1));
    chk($sformatf("%s busy_fall", tag), 64'(busy), 64'd0);
  endtask

  initial begin
    // Reset state
    #1;
    chk("rst in_ready", 64'(in_ready), 64'd0);
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst done", 64'(done), 64'd0);
    chk("rst out_valid", 64'(out_valid), 64'd0);
    chk("rst out_idx", 64'(out_idx), 64'd0);
    chk("rst angle", 64'(cordic_angle), 64'd0);
    chk("rst xin", 64'(cordic_xin), 64'd0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;

    // Stage 2, continuous
    exp_ang = '{32'h00000000, 32'hE0000000, 32'hC0000000, 32'hA0000000};
    opx = '{16384, 16384, 16384, 16384};
    opy = '{0, 0, 0, 0};
    do_stage("s2", 3'd2, 1, 1'b0);
    if (oq_x.size() == 4) begin
      chk_tol("s2 x1", oq_x[1], 11585, 8);   chk_tol("s2 y1", oq_y[1], -11585, 8);
      chk_tol("s2 x2", oq_x[2], 0, 8);       chk_tol("s2 y2", oq_y[2], -16384, 8);
      chk_tol("s2 x3", oq_x[3], -11585, 8);  chk_tol("s2 y3", oq_y[3], -11585, 8);
    end

    // Stage 1
    exp_ang = '{32'h00000000, 32'hC0000000, 32'h00000000, 32'hC0000000};
    opx = '{0, 16384, 0, 0};
    opy = '{0, 0, 0, 0};
    do_stage("s1", 3'd1, 1, 1'b0);
    if (oq_x.size() == 4) begin
      chk_tol("s1 x1", oq_x[1], 0, 8);
      chk_tol("s1 y1", oq_y[1], -16384, 8);
    end

    // Stage 0: identity rotation
    exp_ang = '{32'h0, 32'h0, 32'h0, 32'h0};
    opx = '{1000, 1000, 1000, 1000};
    opy = '{-2000, -2000, -2000, -2000};
    do_stage("s0", 3'd0, 1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      if (i < oq_x.size()) begin
        chk_tol($sformatf("s0 x%0d", i), oq_x[i], 1000, 4);
        chk_tol($sformatf("s0 y%0d", i), oq_y[i], -2000, 4);
      end
    end

    // Stage 2 with gapped in_valid and a start poked while busy
    exp_ang = '{32'h00000000, 32'hE0000000, 32'hC0000000, 32'hA0000000};
    opx = '{16384, 16384, 16384, 16384};
    opy = '{0, 0, 0, 0};
    do_stage("gap", 3'd2, 3, 1'b1);
    chk("gap no_restart", 64'(busy), 64'd0);

    // Stage index beyond range behaves as the last stage
    do_stage("s7", 3'd7, 1, 1'b0);

    // Reset after two accepts in stage 2
    oq_idx.delete(); oq_x.delete(); oq_y.delete(); oq_cyc.delete();
    @(negedge clock); stage = 3'd2; start = 1'b1;
    @(negedge clock); start = 1'b0; in_valid = 1'b1; in_x = 16'sd100; in_y = 16'sd50;
    @(posedge clock); @(posedge clock); #2;
    chk("mid angle_before", 64'(cordic_angle), 64'h00000000E0000000);
    reset_n = 1'b0; in_valid = 1'b0;
    #1;
    chk("mid busy", 64'(busy), 64'd0);
    chk("mid in_ready", 64'(in_ready), 64'd0);
    chk("mid angle", 64'(cordic_angle), 64'd0);
    chk("mid xin", 64'(cordic_xin), 64'd0);
    chk("mid yin", 64'(cordic_yin), 64'd0);
    chk("mid out_valid", 64'(out_valid), 64'd0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    repeat (20) @(negedge clock);
    chk("mid no_out", 64'(oq_idx.size()), 64'd0);
    do_stage("post", 3'd2, 1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
